// File: rtl/maze_view_controller.sv
// -----------------------------------------------------------------------------
// maze_view_controller
//
// Purpose:
//   Per-frame scene sequencer for the maze renderer. On each frame_tick that
//   arrives while idle it applies pending zoom requests, moves the character
//   one tile (subject to walls, maze edges and a move cooldown) and then
//   recomputes the scroll origin so the character stays on screen. All
//   outputs change only during the short IDLE->LOOKUP->VIEW->IDLE sequence
//   that follows frame_tick, i.e. inside vertical blanking.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   frame_tick               1-cycle pulse at start of vertical blanking
//   load, start_x/start_y    place character (highest priority after reset)
//   btn_up/down/left/right   level move requests (priority up>down>left>right)
//   zoom_in, zoom_out        1-cycle pulses, latched until next accepted frame
//   maze_width/maze_height   maze size in tiles
//   path_data                walkability bitmap, bit index = x + MAP_DIM*y
//   char_x/char_y            character tile position
//   x_coord/y_coord          scroll origin (tiles)
//   tile_width/tile_height   log2 tile pixel size
//   busy                     sequence in progress (state != IDLE)
//   moved                    1-cycle pulse when a move commits
// -----------------------------------------------------------------------------
module maze_view_controller #(
    parameter int MAP_DIM       = 64,
    parameter int MIN_SHIFT     = 2,
    parameter int MAX_SHIFT     = 5,
    parameter int DEFAULT_SHIFT = 4,
    parameter int MOVE_FRAMES   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_tick,
    input  logic          load,
    input  logic [6:0]    start_x,
    input  logic [6:0]    start_y,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          zoom_in,
    input  logic          zoom_out,
    input  logic [6:0]    maze_width,
    input  logic [6:0]    maze_height,
    input  logic [4095:0] path_data,
    output logic [6:0]    char_x,
    output logic [6:0]    char_y,
    output logic [6:0]    x_coord,
    output logic [6:0]    y_coord,
    output logic [6:0]    tile_width,
    output logic [6:0]    tile_height,
    output logic          busy,
    output logic          moved
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_VIEW   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    state_e     state_q;
    dir_e       dir_q;
    logic [6:0] char_x_q;
    logic [6:0] char_y_q;
    logic [6:0] x_coord_q;
    logic [6:0] y_coord_q;
    logic [6:0] shift_q;
    logic [7:0] cooldown_q;
    logic       zin_q;
    logic       zout_q;
    logic       moved_q;

    logic       zin_s;
    logic       zout_s;
    logic [6:0] shift_d;
    logic       btn_any_s;
    dir_e       dir_d;
    logic [6:0] tgt_x_s;
    logic [6:0] tgt_y_s;
    logic       in_bounds_s;
    logic [13:0] idx_s;
    logic       walkable_s;
    logic       accept_s;
    logic [9:0] view_w_s;
    logic [9:0] view_h_s;
    logic [6:0] x_coord_d;
    logic [6:0] y_coord_d;

    // Scroll origin along one axis: centre the character, clamp to
    // [0, maze_dim - view_dim]; all arithmetic in 10 bits, never wrapping.
    function automatic logic [6:0] view_origin(input logic [6:0] pos,
                                               input logic [6:0] maze_dim,
                                               input logic [9:0] view_dim);
        logic [9:0] half;
        logic [9:0] pos_ext;
        logic [9:0] dim_ext;
        logic [9:0] diff;
        logic [9:0] max_org;
        logic [9:0] org;
        half    = view_dim >> 1;
        pos_ext = {3'b000, pos};
        dim_ext = {3'b000, maze_dim};
        diff    = 10'd0;
        max_org = 10'd0;
        if (dim_ext <= view_dim) begin
            org = 10'd0;
        end else if (pos_ext <= half) begin
            org = 10'd0;
        end else begin
            diff    = pos_ext - half;
            max_org = dim_ext - view_dim;
            if (diff > max_org) begin
                org = max_org;
            end else begin
                org = diff;
            end
        end
        return org[6:0];
    endfunction

    // A zoom pulse coinciding with the consuming frame_tick still counts.
    assign zin_s     = zin_q | zoom_in;
    assign zout_s    = zout_q | zoom_out;
    assign btn_any_s = btn_up | btn_down | btn_left | btn_right;

    // Saturating zoom; simultaneous in+out cancel.
    always_comb begin
        shift_d = shift_q;
        if (zin_s && !zout_s) begin
            if (shift_q < 7'(MAX_SHIFT)) begin
                shift_d = shift_q + 7'd1;
            end else begin
                shift_d = shift_q;
            end
        end else if (zout_s && !zin_s) begin
            if (shift_q > 7'(MIN_SHIFT)) begin
                shift_d = shift_q - 7'd1;
            end else begin
                shift_d = shift_q;
            end
        end else begin
            shift_d = shift_q;
        end
    end

    // Direction priority encoder: up > down > left > right.
    always_comb begin
        dir_d = DIR_RIGHT;
        if (btn_up) begin
            dir_d = DIR_UP;
        end else if (btn_down) begin
            dir_d = DIR_DOWN;
        end else if (btn_left) begin
            dir_d = DIR_LEFT;
        end else begin
            dir_d = DIR_RIGHT;
        end
    end

    // Move target, edge check and wall lookup for the latched direction.
    always_comb begin
        tgt_x_s     = char_x_q;
        tgt_y_s     = char_y_q;
        in_bounds_s = 1'b0;
        case (dir_q)
            DIR_UP: begin
                tgt_y_s     = char_y_q - 7'd1;
                in_bounds_s = (char_y_q != 7'd0);
            end
            DIR_DOWN: begin
                tgt_y_s     = char_y_q + 7'd1;
                in_bounds_s = (({1'b0, char_y_q} + 8'd1) < {1'b0, maze_height});
            end
            DIR_LEFT: begin
                tgt_x_s     = char_x_q - 7'd1;
                in_bounds_s = (char_x_q != 7'd0);
            end
            DIR_RIGHT: begin
                tgt_x_s     = char_x_q + 7'd1;
                in_bounds_s = (({1'b0, char_x_q} + 8'd1) < {1'b0, maze_width});
            end
            default: begin
                in_bounds_s = 1'b0;
            end
        endcase
        idx_s = 14'(tgt_x_s) + 14'(MAP_DIM) * 14'(tgt_y_s);
        // A position loaded outside the bitmap can produce an index past its
        // end; treat that as a wall rather than reading garbage.
        if (idx_s < 14'd4096) begin
            walkable_s = path_data[idx_s[11:0]];
        end else begin
            walkable_s = 1'b0;
        end
        accept_s = in_bounds_s & walkable_s;
    end

    // Viewport in tiles and the resulting scroll origin.
    always_comb begin
        view_w_s  = 10'd640 >> shift_q;
        view_h_s  = 10'd480 >> shift_q;
        x_coord_d = view_origin(char_x_q, maze_width, view_w_s);
        y_coord_d = view_origin(char_y_q, maze_height, view_h_s);
    end

    // Sequencer FSM and all registered scene state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_UP;
            char_x_q   <= 7'd0;
            char_y_q   <= 7'd0;
            x_coord_q  <= 7'd0;
            y_coord_q  <= 7'd0;
            shift_q    <= 7'(DEFAULT_SHIFT);
            cooldown_q <= 8'd0;
            zin_q      <= 1'b0;
            zout_q     <= 1'b0;
            moved_q    <= 1'b0;
        end else begin
            moved_q <= 1'b0;
            if (zoom_in) begin
                zin_q <= 1'b1;
            end else begin
                zin_q <= zin_q;
            end
            if (zoom_out) begin
                zout_q <= 1'b1;
            end else begin
                zout_q <= zout_q;
            end
            if (load) begin
                // Discards any in-flight move; VIEW refreshes the origin.
                char_x_q   <= start_x;
                char_y_q   <= start_y;
                cooldown_q <= 8'd0;
                state_q    <= ST_VIEW;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (frame_tick) begin
                            shift_q <= shift_d;
                            zin_q   <= 1'b0;
                            zout_q  <= 1'b0;
                            if (cooldown_q != 8'd0) begin
                                cooldown_q <= cooldown_q - 8'd1;
                                state_q    <= ST_VIEW;
                            end else if (btn_any_s) begin
                                dir_q   <= dir_d;
                                state_q <= ST_LOOKUP;
                            end else begin
                                state_q <= ST_VIEW;
                            end
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_LOOKUP: begin
                        if (accept_s) begin
                            char_x_q   <= tgt_x_s;
                            char_y_q   <= tgt_y_s;
                            moved_q    <= 1'b1;
                            cooldown_q <= 8'(MOVE_FRAMES - 1);
                        end else begin
                            cooldown_q <= cooldown_q;
                        end
                        state_q <= ST_VIEW;
                    end
                    ST_VIEW: begin
                        x_coord_q <= x_coord_d;
                        y_coord_q <= y_coord_d;
                        state_q   <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign char_x      = char_x_q;
    assign char_y      = char_y_q;
    assign x_coord     = x_coord_q;
    assign y_coord     = y_coord_q;
    assign tile_width  = shift_q;
    assign tile_height = shift_q;
    assign busy        = (state_q != ST_IDLE);
    assign moved       = moved_q;

endmodule

// File: tb/tb_maze_view_controller.sv
// -----------------------------------------------------------------------------
// tb_maze_view_controller
//
// Directed self-checking bench for maze_view_controller. Inputs are driven on
// the falling edge, outputs sampled on the falling edge; expected values are
// hand-computed constants or a trivial per-frame step model.
// -----------------------------------------------------------------------------
module tb_maze_view_controller;

    logic          clk;
    logic          reset;
    logic          frame_tick;
    logic          load;
    logic [6:0]    start_x;
    logic [6:0]    start_y;
    logic          btn_up;
    logic          btn_down;
    logic          btn_left;
    logic          btn_right;
    logic          zoom_in;
    logic          zoom_out;
    logic [6:0]    maze_width;
    logic [6:0]    maze_height;
    logic [4095:0] path_data;
    logic [6:0]    char_x;
    logic [6:0]    char_y;
    logic [6:0]    x_coord;
    logic [6:0]    y_coord;
    logic [6:0]    tile_width;
    logic [6:0]    tile_height;
    logic          busy;
    logic          moved;

    int pass_cnt  = 0;
    int chk_cnt   = 0;
    int moved_cnt = 0;

    maze_view_controller dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .load        (load),
        .start_x     (start_x),
        .start_y     (start_y),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .zoom_in     (zoom_in),
        .zoom_out    (zoom_out),
        .maze_width  (maze_width),
        .maze_height (maze_height),
        .path_data   (path_data),
        .char_x      (char_x),
        .char_y      (char_y),
        .x_coord     (x_coord),
        .y_coord     (y_coord),
        .tile_width  (tile_width),
        .tile_height (tile_height),
        .busy        (busy),
        .moved       (moved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // moved is a one-cycle pulse, so one falling-edge sample per pulse.
    always @(negedge clk) begin
        if (moved) moved_cnt <= moved_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic run_frame();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic load_char(input logic [6:0] x, input logic [6:0] y);
        @(negedge clk);
        load = 1'b1; start_x = x; start_y = y;
        @(negedge clk) load = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_zoom(input logic zi, input logic zo);
        @(negedge clk);
        zoom_in = zi; zoom_out = zo;
        @(negedge clk);
        zoom_in = 1'b0; zoom_out = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_char_x"}, 32'(char_x), 32'd0);
        check({tag, "_char_y"}, 32'(char_y), 32'd0);
        check({tag, "_x_coord"}, 32'(x_coord), 32'd0);
        check({tag, "_y_coord"}, 32'(y_coord), 32'd0);
        check({tag, "_tile_w"}, 32'(tile_width), 32'd4);
        check({tag, "_tile_h"}, 32'(tile_height), 32'd4);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_moved"}, 32'(moved), 32'd0);
    endtask

    initial begin
        int mv0;
        int exp_x;
        reset = 1'b0; frame_tick = 1'b0; load = 1'b0;
        start_x = 7'd0; start_y = 7'd0;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        zoom_in = 1'b0; zoom_out = 1'b0;
        maze_width = 7'd8; maze_height = 7'd8;
        path_data = '1;

        // Reset state
        do_reset();
        @(negedge clk);
        check_reset_outputs("rst");

        // Walk right in an open 8x8 maze: one step per 8 frames, stop at x=7
        load_char(7'd3, 7'd3);
        check("load_x", 32'(char_x), 32'd3);
        mv0 = moved_cnt;
        btn_right = 1'b1;
        for (int f = 0; f < 40; f++) begin
            run_frame();
            exp_x = 3 + ((f / 8 + 1) > 4 ? 4 : (f / 8 + 1));
            if (f == 0 || f == 7 || f == 8 || f == 16 || f == 24 || f == 39)
                check($sformatf("walk_f%0d", f), 32'(char_x), 32'(exp_x));
        end
        btn_right = 1'b0;
        @(negedge clk);
        check("walk_y", 32'(char_y), 32'd3);
        check("walk_moves", 32'(moved_cnt - mv0), 32'd4);

        // Wall to the right blocks and leaves no cooldown behind
        path_data[4 + 64 * 3] = 1'b0;
        load_char(7'd3, 7'd3);
        mv0 = moved_cnt;
        btn_right = 1'b1;
        repeat (10) run_frame();
        btn_right = 1'b0;
        check("wall_x", 32'(char_x), 32'd3);
        check("wall_moves", 32'(moved_cnt - mv0), 32'd0);
        btn_up = 1'b1;
        run_frame();
        btn_up = 1'b0;
        check("nocool_y", 32'(char_y), 32'd2);
        check("nocool_moves", 32'(moved_cnt - mv0), 32'd1);

        // Up beats left
        path_data = '1;
        load_char(7'd3, 7'd3);
        btn_up = 1'b1; btn_left = 1'b1;
        run_frame();
        btn_up = 1'b0; btn_left = 1'b0;
        check("prio_x", 32'(char_x), 32'd3);
        check("prio_y", 32'(char_y), 32'd2);

        // Zoom saturation and cancellation
        pulse_zoom(1'b1, 1'b0); run_frame(); check("zin1", 32'(tile_width), 32'd5);
        pulse_zoom(1'b1, 1'b0); run_frame(); check("zin2", 32'(tile_width), 32'd5);
        pulse_zoom(1'b1, 1'b0); run_frame(); check("zin3", 32'(tile_height), 32'd5);
        pulse_zoom(1'b1, 1'b1); run_frame(); check("zboth", 32'(tile_width), 32'd5);
        pulse_zoom(1'b0, 1'b1); run_frame(); check("zout1", 32'(tile_width), 32'd4);
        pulse_zoom(1'b0, 1'b1); run_frame(); check("zout2", 32'(tile_width), 32'd3);
        pulse_zoom(1'b0, 1'b1); run_frame(); check("zout3", 32'(tile_width), 32'd2);
        pulse_zoom(1'b0, 1'b1); run_frame(); check("zout4", 32'(tile_height), 32'd2);
        pulse_zoom(1'b1, 1'b0); pulse_zoom(1'b0, 1'b1); run_frame();
        check("zsplit", 32'(tile_width), 32'd2);

        // Scrolling in a 64x64 maze
        do_reset();
        maze_width = 7'd64; maze_height = 7'd64;
        load_char(7'd50, 7'd50);
        check("scr50_x", 32'(x_coord), 32'd24);
        check("scr50_y", 32'(y_coord), 32'd34);
        load_char(7'd63, 7'd63);
        check("scr63_x", 32'(x_coord), 32'd24);
        check("scr63_y", 32'(y_coord), 32'd34);
        load_char(7'd5, 7'd5);
        check("scr5_x", 32'(x_coord), 32'd0);
        check("scr5_y", 32'(y_coord), 32'd0);
        load_char(7'd50, 7'd50);
        pulse_zoom(1'b1, 1'b0); run_frame();
        check("scrz5_x", 32'(x_coord), 32'd40);
        check("scrz5_y", 32'(y_coord), 32'd43);
        load_char(7'd20, 7'd10);
        check("scrmid_x", 32'(x_coord), 32'd10);
        check("scrmid_y", 32'(y_coord), 32'd3);
        load_char(7'd50, 7'd50);
        pulse_zoom(1'b0, 1'b1); run_frame();
        pulse_zoom(1'b0, 1'b1); run_frame();
        pulse_zoom(1'b0, 1'b1); run_frame();
        check("scrz2_tile", 32'(tile_width), 32'd2);
        check("scrz2_x", 32'(x_coord), 32'd0);
        check("scrz2_y", 32'(y_coord), 32'd0);

        // load during LOOKUP of an accepted move wins, no moved pulse
        do_reset();
        maze_width = 7'd8; maze_height = 7'd8;
        load_char(7'd3, 7'd3);
        mv0 = moved_cnt;
        btn_right = 1'b1;
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; load = 1'b1; start_x = 7'd2; start_y = 7'd2;
        @(negedge clk);
        load = 1'b0; btn_right = 1'b0;
        check("ldlk_x", 32'(char_x), 32'd2);
        check("ldlk_y", 32'(char_y), 32'd2);
        check("ldlk_moved", 32'(moved), 32'd0);
        repeat (3) @(negedge clk);
        check("ldlk_moves", 32'(moved_cnt - mv0), 32'd0);

        // reset asserted in VIEW clears everything on the next edge
        maze_width = 7'd64; maze_height = 7'd64;
        load_char(7'd50, 7'd50);
        check("pre_x_coord", 32'(x_coord), 32'd24);
        pulse_zoom(1'b1, 1'b0);
        btn_right = 1'b1;
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        @(negedge clk);
        check("view_char_x", 32'(char_x), 32'd51);
        check("view_busy", 32'(busy), 32'd1);
        check("view_tile", 32'(tile_width), 32'd5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; btn_right = 1'b0;
        check_reset_outputs("rstview");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
